output_port_4_serial: RTL
=========================

// Module: output_port_4_serial
//
// PURPOSE
// - SAP-II serial output port: transmit side of the serial link whose receive side is the serial input port.
// - Captures a byte from WBUS when the controller asserts Lo4; shifts it out LSB-first as a framed stream.
// - Frame: start(0), data bits, [parity], stop(1). busy is exposed for the program to poll before the next OUT.
//
// PARAMETERS
// - DATA_WIDTH  8   bits per frame; WBUS width
// - BAUD_DIV    4   CLK cycles per serial bit; legal range 1..255
//
// PORTS
// - CLK        in   1           system clock, all logic on posedge
// - CLR        in   1           synchronous clear, active-high
// - WBUS       in   DATA_WIDTH  byte to transmit, sampled on accepted load
// - Lo4        in   1           load request from controller
// - serial_out out  1           serial line; idles high
// - busy       out  1           1 while a frame is in flight
// - tx_done    out  1           one-cycle pulse on last cycle of stop bit
// - overrun    out  1           sticky: Lo4 seen while busy
//
// BEHAVIOUR
// - Reset (CLR=1 at posedge): serial_out=1, busy=0, tx_done=0, overrun=0, state=IDLE, shift reg/counters=0.
// - CLR mid-frame aborts immediately: line returns high next edge; no tx_done pulse.
// - Load accepted when Lo4=1 and busy=0 at a posedge: WBUS latched into shift reg, state->START.
// - Latency: serial_out=0 and busy=1 from the edge that accepts the load.
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - each non-IDLE state holds serial_out for exactly BAUD_DIV cycles (baud counter 0..BAUD_DIV-1).
//   - DATA: bit index 0..DATA_WIDTH-1, serial_out = shift_reg[0], shift right at each bit end.
//   - STOP: serial_out=1; tx_done=1 on final cycle; next edge busy=0, IDLE.
// - Frame length: (DATA_WIDTH+2)*BAUD_DIV cycles, +BAUD_DIV with parity.
// - Lo4 while busy (incl. the tx_done cycle): ignored, WBUS not sampled, overrun set; cleared only by CLR.
// - Back-to-back: earliest next accepted load is the cycle busy=0, i.e. 1 idle cycle (line high) between frames.
// - Lo4 held high in IDLE: reloads every time busy falls (one frame per accepted load).
// - BAUD_DIV=1: one bit per cycle; counters must not underflow or wrap.
// - WBUS changes after acceptance have no effect on the frame in flight.
//
// CONFIGURATION
// - Macro SERIAL_TX_PARITY_EN.
// - Defined: PARITY state between DATA and STOP, serial_out = even parity (XOR of captured byte), BAUD_DIV cycles.
// - Undefined: no PARITY state; DATA goes directly to STOP; frame = (DATA_WIDTH+2)*BAUD_DIV.
//
// TESTING
// - CLR=1 2 cycles -> serial_out=1, busy=0, tx_done=0, overrun=0.
// - BAUD_DIV=4, load 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done at cycle 40; busy low at 41.
// - SERIAL_TX_PARITY_EN, load 8'h07 -> parity bit 1 after data; load 8'h03 -> parity 0; frame 44 cycles.
// - Lo4 pulsed at cycle 10 of frame with WBUS=8'hFF -> frame unchanged, overrun=1 until CLR.
// - CLR asserted during data bit 3 -> next edge serial_out=1, busy=0, no tx_done; new load of 8'h3C sent correctly.
// - Lo4 held high, WBUS=8'h81, BAUD_DIV=1 -> consecutive frames separated by exactly one high idle cycle.

Source files
------------

// File: rtl/output_port_4_serial.sv
// SAP-II serial output port: captures WBUS on Lo4 and shifts it out LSB-first
// framed as start(0), data, [even parity when SERIAL_TX_PARITY_EN is defined], stop(1).
module output_port_4_serial #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_DIV   = 4
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] WBUS,
  input  logic                  Lo4,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  overrun
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] LAST_CNT = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_idx;
`ifdef SERIAL_TX_PARITY_EN
  logic                  parity;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == LAST_CNT);

  // Outputs are registered with the value for the cycle being entered, so tx_done
  // is raised one edge ahead of the final stop-bit cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state      <= IDLE;
      shift_reg  <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity     <= 1'b0;
`endif
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (Lo4 && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (Lo4) begin
            shift_reg  <= WBUS;
`ifdef SERIAL_TX_PARITY_EN
            parity     <= ^WBUS;
`endif
            baud_cnt   <= '0;
            bit_idx    <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            serial_out <= shift_reg[0];
            state      <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
              serial_out <= parity;
              state      <= PARITY;
`else
              serial_out <= 1'b1;
              tx_done    <= (LAST_CNT == '0);
              state      <= STOP;
`endif
            end else begin
              bit_idx    <= bit_idx + BIT_W'(1);
              serial_out <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt   <= '0;
            serial_out <= 1'b1;
            tx_done    <= (LAST_CNT == '0);
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
            tx_done  <= ((baud_cnt + BAUD_W'(1)) == LAST_CNT);
          end
        end

        default: begin
          serial_out <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
